// File: rtl/ahb_arbiter_if.sv
// Arbitration bundle between the AHB masters/bus fabric and the central arbiter.
// HGRANT/HMASTER/HMASTLOCK flow back from the arbiter; everything else flows in.
interface ahb_arbiter_if #(
  parameter int NUM_MST = 4
);
  logic [NUM_MST-1:0] HBUSREQ;
  logic [NUM_MST-1:0] HLOCK;
  logic [1:0]         HTRANS;
  logic               HREADY;
  logic [1:0]         HRESP;
  logic [NUM_MST-1:0] HSPLIT;
  logic [NUM_MST-1:0] HGRANT;
  logic [3:0]         HMASTER;
  logic               HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HREADY, HRESP, HSPLIT,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HREADY, HRESP, HSPLIT,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Central AHB arbiter: round-robin grant with tenure limit, locked hold and SPLIT masking.
// HMASTER/HMASTLOCK trail HGRANT by one HREADY cycle to steer the address/data mux.
module ahb_arbiter #(
  parameter int NUM_MST   = 4,
  parameter int DEF_MST   = 0,
  parameter int MAX_BEATS = 16
) (
  input logic          HCLK,
  input logic          HRST_N,
  ahb_arbiter_if.slave bus
);
  localparam int            BW       = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] BEAT_LIM = BW'(MAX_BEATS);
  localparam logic [3:0]    DEF_IDX  = 4'(DEF_MST);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_RETRY   = 2'b10;
  localparam logic [1:0] RESP_SPLIT   = 2'b11;

  logic [3:0]         gnt_idx;
  logic [3:0]         rr_ptr;
  logic [3:0]         hmaster_q;
  logic               hmastlock_q;
  logic [NUM_MST-1:0] split_mask;
  logic [BW-1:0]      beat_cnt;
  logic               rearb_pend;

  logic [NUM_MST-1:0] elig;
  logic [NUM_MST-1:0] split_set;
  logic [NUM_MST-1:0] hgrant;
  logic [15:0]        req16;
  logic [15:0]        lock16;
  logic [15:0]        elig16;
  logic [3:0]         sel_idx;
  logic               sel_found;
  logic               cur_lock;
  logic               others_elig;
  logic               tenure_hit;
  logic               arb_pt;
  logic               beat_evt;
  logic               resp_first;
  logic               resp_split;

  // Vectors widened to 16 so the 4-bit indices can address them directly.
  always_comb begin
    req16       = 16'(bus.HBUSREQ);
    lock16      = 16'(bus.HLOCK);
    elig        = bus.HBUSREQ & ~split_mask;
    elig16      = 16'(elig);
    cur_lock    = lock16[gnt_idx] & req16[gnt_idx];
    others_elig = |(elig16 & ~(16'd1 << gnt_idx));
    tenure_hit  = (MAX_BEATS != 0) && (beat_cnt >= BEAT_LIM) && others_elig;
    arb_pt      = bus.HREADY && !cur_lock &&
                  (!req16[gnt_idx] || (bus.HTRANS == TRANS_IDLE) || rearb_pend || tenure_hit);
    beat_evt    = bus.HREADY && ((bus.HTRANS == TRANS_NONSEQ) || (bus.HTRANS == TRANS_SEQ));
    resp_first  = !bus.HREADY && ((bus.HRESP == RESP_SPLIT) || (bus.HRESP == RESP_RETRY));
    resp_split  = !bus.HREADY && (bus.HRESP == RESP_SPLIT) && (hmaster_q != DEF_IDX);
  end

  // Circular scan starting one past the last winner; falls back to the default master.
  always_comb begin
    int idx;
    idx       = 0;
    sel_idx   = DEF_IDX;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_MST; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      if (!sel_found && elig16[4'(idx)]) begin
        sel_idx   = 4'(idx);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    split_set = '0;
    hgrant    = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      split_set[i] = resp_split && (hmaster_q == 4'(i));
      hgrant[i]    = (gnt_idx == 4'(i));
    end
  end

  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      gnt_idx     <= DEF_IDX;
      rr_ptr      <= DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
      split_mask  <= '0;
      beat_cnt    <= '0;
      rearb_pend  <= 1'b0;
    end else begin
      if (bus.HREADY) begin
        hmaster_q   <= gnt_idx;
        hmastlock_q <= cur_lock;
      end
      if (arb_pt) begin
        gnt_idx <= sel_idx;
        rr_ptr  <= sel_idx;
      end
      if (resp_first) begin
        rearb_pend <= 1'b1;
      end else if (arb_pt) begin
        rearb_pend <= 1'b0;
      end
      // A new split on a bit wins over a same-cycle resume of that bit.
      split_mask <= (split_mask & ~bus.HSPLIT) | split_set;
      if (arb_pt && (sel_idx != gnt_idx)) begin
        beat_cnt <= '0;
      end else if (beat_evt && (MAX_BEATS != 0) && (beat_cnt < BEAT_LIM)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign bus.HGRANT    = hgrant;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios with fixed expectations plus
// a randomized run compared every cycle against a rule-level reference model.
module tb_ahb_arbiter;
  localparam int N   = 4;
  localparam int DEF = 0;
  localparam int MB  = 4;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] RETRY  = 2'b10;
  localparam logic [1:0] SPLIT  = 2'b11;

  logic HCLK   = 1'b0;
  logic HRST_N = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  ahb_arbiter_if #(.NUM_MST(N)) bus ();

  ahb_arbiter #(.NUM_MST(N), .DEF_MST(DEF), .MAX_BEATS(MB)) dut (
    .HCLK   (HCLK),
    .HRST_N (HRST_N),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: plain integers following the arbitration rules.
  int         m_gnt, m_owner, m_ptr, m_beats;
  bit         m_lock, m_pend;
  logic [N-1:0] m_mask;

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int grant_index(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_gnt = DEF; m_owner = DEF; m_ptr = DEF; m_beats = 0;
    m_lock = 1'b0; m_pend = 1'b0; m_mask = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] req, lk, elig, n_mask;
    bit held, arb, found, n_lock, n_pend;
    int others, pick, cand, n_gnt, n_ptr, n_beats, n_owner;
    req    = bus.HBUSREQ;
    lk     = bus.HLOCK;
    elig   = req & ~m_mask;
    held   = lk[m_gnt] && req[m_gnt];
    others = 0;
    for (int i = 0; i < N; i++) if (elig[i] && i != m_gnt) others++;
    arb = bus.HREADY && !held &&
          (!req[m_gnt] || bus.HTRANS == IDLE || m_pend || (MB != 0 && m_beats >= MB && others > 0));
    pick  = DEF;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = (m_ptr + k) % N;
      if (!found && elig[cand]) begin pick = cand; found = 1'b1; end
    end
    n_gnt = m_gnt; n_ptr = m_ptr; n_owner = m_owner; n_lock = m_lock; n_pend = m_pend;
    if (bus.HREADY) begin n_owner = m_gnt; n_lock = held; end
    if (arb) begin n_gnt = pick; n_ptr = pick; n_pend = 1'b0; end
    if (!bus.HREADY && (bus.HRESP == SPLIT || bus.HRESP == RETRY)) n_pend = 1'b1;
    n_mask = m_mask & ~bus.HSPLIT;
    if (!bus.HREADY && bus.HRESP == SPLIT && m_owner != DEF) n_mask[m_owner] = 1'b1;
    if (n_gnt != m_gnt) n_beats = 0;
    else if (bus.HREADY && (bus.HTRANS == NONSEQ || bus.HTRANS == SEQ))
      n_beats = (m_beats + 1 > MB) ? MB : m_beats + 1;
    else n_beats = m_beats;
    m_gnt = n_gnt; m_ptr = n_ptr; m_owner = n_owner; m_lock = n_lock;
    m_pend = n_pend; m_mask = n_mask; m_beats = n_beats;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lk, input logic [1:0] tr,
                       input logic rdy, input logic [1:0] rs, input logic [N-1:0] spl);
    bus.HBUSREQ = req; bus.HLOCK = lk; bus.HTRANS = tr;
    bus.HREADY = rdy; bus.HRESP = rs; bus.HSPLIT = spl;
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_step();
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    drive('0, '0, IDLE, 1'b1, OKAY, '0);
    HRST_N = 1'b0;
    model_reset();
    repeat (2) @(negedge HCLK);
    HRST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive('0, '0, IDLE, 1'b1, OKAY, '0);
      tick();
      checks++;
      if (bus.HGRANT !== 4'b0001) begin
        failures++; $display("FAIL reset_grant cycle %0d: got %b expected 0001", c, bus.HGRANT);
      end
      checks++;
      if (bus.HMASTER !== 4'd0) begin
        failures++; $display("FAIL reset_hmaster cycle %0d: got %0d expected 0", c, bus.HMASTER);
      end
      checks++;
      if (bus.HMASTLOCK !== 1'b0) begin
        failures++; $display("FAIL reset_hmastlock cycle %0d: got %b expected 0", c, bus.HMASTLOCK);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq[6] = '{1, 2, 3, 1, 2, 3};
    int nchg, last, gi;
    do_reset();
    nchg = 0;
    last = DEF;
    for (int c = 0; c < 12; c++) begin
      drive(4'b1110, '0, (c % 2 == 0) ? NONSEQ : IDLE, 1'b1, OKAY, '0);
      tick();
      checks++;
      if (bus.HMASTER !== 4'(m_owner)) begin
        failures++; $display("FAIL rr_hmaster cycle %0d: got %0d expected %0d", c, bus.HMASTER, m_owner);
      end
      gi = grant_index(bus.HGRANT);
      if (gi != last && nchg < 6) begin
        checks++;
        if (gi != exp_seq[nchg]) begin
          failures++; $display("FAIL rr_sequence step %0d: got %0d expected %0d", nchg, gi, exp_seq[nchg]);
        end
        nchg++;
      end
      last = gi;
    end
    checks++;
    if (nchg != 6) begin
      failures++; $display("FAIL rr_changes: got %0d grant changes expected 6", nchg);
    end
  endtask

  task automatic test_tenure();
    logic [N-1:0] exp_g[6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(4'b0110, '0, SEQ, 1'b1, OKAY, '0);
      tick();
      checks++;
      if (bus.HGRANT !== exp_g[c]) begin
        failures++; $display("FAIL tenure_grant cycle %0d: got %b expected %b", c, bus.HGRANT, exp_g[c]);
      end
    end
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(4'b0010, '0, SEQ, 1'b1, OKAY, '0);
      tick();
      checks++;
      if (bus.HGRANT !== 4'b0010) begin
        failures++; $display("FAIL tenure_alone cycle %0d: got %b expected 0010", c, bus.HGRANT);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    drive(4'b0100, 4'b0100, NONSEQ, 1'b1, OKAY, '0);
    tick();
    for (int c = 0; c < 20; c++) begin
      drive(4'b1110, 4'b0100, SEQ, 1'b1, OKAY, '0);
      tick();
      checks++;
      if (bus.HGRANT !== 4'b0100) begin
        failures++; $display("FAIL lock_grant cycle %0d: got %b expected 0100", c, bus.HGRANT);
      end
      checks++;
      if (bus.HMASTLOCK !== 1'b1) begin
        failures++; $display("FAIL lock_hmastlock cycle %0d: got %b expected 1", c, bus.HMASTLOCK);
      end
    end
    drive(4'b1010, '0, NONSEQ, 1'b1, OKAY, '0);
    tick();
    checks++;
    if (bus.HGRANT !== 4'b1000) begin
      failures++; $display("FAIL lock_release_grant: got %b expected 1000", bus.HGRANT);
    end
    checks++;
    if (bus.HMASTLOCK !== 1'b0) begin
      failures++; $display("FAIL lock_release_hmastlock: got %b expected 0", bus.HMASTLOCK);
    end
  endtask

  task automatic test_split();
    do_reset();
    drive(4'b1000, '0, NONSEQ, 1'b1, OKAY, '0); tick();
    drive(4'b1000, '0, NONSEQ, 1'b1, OKAY, '0); tick();
    checks++;
    if (bus.HMASTER !== 4'd3) begin
      failures++; $display("FAIL split_setup_hmaster: got %0d expected 3", bus.HMASTER);
    end
    drive(4'b1010, '0, NONSEQ, 1'b0, SPLIT, '0); tick();
    checks++;
    if (bus.HGRANT !== 4'b1000 || bus.HMASTER !== 4'd3) begin
      failures++; $display("FAIL split_first_freeze: got %b/%0d expected 1000/3", bus.HGRANT, bus.HMASTER);
    end
    drive(4'b1010, '0, NONSEQ, 1'b1, SPLIT, '0); tick();
    checks++;
    if (bus.HGRANT !== 4'b0010) begin
      failures++; $display("FAIL split_leave: got %b expected 0010", bus.HGRANT);
    end
    for (int c = 0; c < 4; c++) begin
      drive(4'b1010, '0, IDLE, 1'b1, OKAY, '0); tick();
      checks++;
      if (bus.HGRANT !== 4'b0010) begin
        failures++; $display("FAIL split_masked cycle %0d: got %b expected 0010", c, bus.HGRANT);
      end
    end
    drive(4'b1010, '0, IDLE, 1'b1, OKAY, 4'b1000); tick();
    drive(4'b1010, '0, IDLE, 1'b1, OKAY, '0); tick();
    checks++;
    if (bus.HGRANT !== 4'b1000) begin
      failures++; $display("FAIL split_resume: got %b expected 1000", bus.HGRANT);
    end
    drive(4'b1010, '0, NONSEQ, 1'b1, OKAY, '0); tick();
    drive(4'b1010, '0, NONSEQ, 1'b0, SPLIT, 4'b1000); tick();
    drive(4'b1010, '0, NONSEQ, 1'b1, SPLIT, '0); tick();
    checks++;
    if (bus.HGRANT !== 4'b0010) begin
      failures++; $display("FAIL split_setclr_leave: got %b expected 0010", bus.HGRANT);
    end
    for (int c = 0; c < 3; c++) begin
      drive(4'b1010, '0, IDLE, 1'b1, OKAY, '0); tick();
      checks++;
      if (bus.HGRANT !== 4'b0010) begin
        failures++; $display("FAIL split_setclr_masked cycle %0d: got %b expected 0010", c, bus.HGRANT);
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    drive(4'b0010, '0, NONSEQ, 1'b1, OKAY, '0); tick();
    drive(4'b0010, '0, NONSEQ, 1'b1, OKAY, '0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(N'($urandom), N'($urandom), IDLE, 1'b0, OKAY, '0);
      tick();
      checks++;
      if (bus.HGRANT !== 4'b0010 || bus.HMASTER !== 4'd1 || bus.HMASTLOCK !== 1'b0) begin
        failures++;
        $display("FAIL wait_freeze cycle %0d: got %b/%0d/%b expected 0010/1/0",
                 c, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK);
      end
    end
    drive(4'b0100, '0, IDLE, 1'b1, OKAY, '0); tick();
    checks++;
    if (bus.HGRANT !== 4'b0100 || bus.HMASTER !== 4'd1) begin
      failures++; $display("FAIL wait_resume: got %b/%0d expected 0100/1", bus.HGRANT, bus.HMASTER);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b1000, '0, NONSEQ, 1'b1, OKAY, '0); tick();
    drive(4'b1000, '0, NONSEQ, 1'b1, OKAY, '0); tick();
    drive(4'b1010, '0, NONSEQ, 1'b0, SPLIT, '0); tick();
    drive(4'b1010, '0, NONSEQ, 1'b1, SPLIT, '0);
    #2 HRST_N = 1'b0;
    #1;
    checks++;
    if (bus.HGRANT !== 4'b0001 || bus.HMASTER !== 4'd0 || bus.HMASTLOCK !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got %b/%0d/%b expected 0001/0/0", bus.HGRANT, bus.HMASTER, bus.HMASTLOCK);
    end
    model_reset();
    @(negedge HCLK);
    HRST_N = 1'b1;
    drive(4'b1000, '0, IDLE, 1'b1, OKAY, '0); tick();
    checks++;
    if (bus.HGRANT !== 4'b1000) begin
      failures++; $display("FAIL reset_mid_mask_cleared: got %b expected 1000", bus.HGRANT);
    end
  endtask

  task automatic test_random();
    bit         resp_wait;
    logic [1:0] held_resp;
    do_reset();
    resp_wait = 1'b0;
    held_resp = OKAY;
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] req, lk, spl;
      logic [1:0]   tr, rs;
      logic         rdy;
      req = N'($urandom);
      lk  = req & N'($urandom) & N'($urandom);
      tr  = 2'($urandom);
      spl = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      if (resp_wait) begin
        rdy = 1'b1; rs = held_resp; resp_wait = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        rdy = 1'b0; rs = $urandom_range(0, 1) ? SPLIT : RETRY;
        held_resp = rs; resp_wait = 1'b1;
      end else begin
        rdy = ($urandom_range(0, 7) != 0); rs = OKAY;
      end
      drive(req, lk, tr, rdy, rs, spl);
      tick();
      checks++;
      if (bus.HGRANT !== onehot(m_gnt)) begin
        failures++; $display("FAIL rand_grant cycle %0d: got %b expected %b", c, bus.HGRANT, onehot(m_gnt));
      end
      checks++;
      if (bus.HMASTER !== 4'(m_owner)) begin
        failures++; $display("FAIL rand_hmaster cycle %0d: got %0d expected %0d", c, bus.HMASTER, m_owner);
      end
      checks++;
      if (bus.HMASTLOCK !== m_lock) begin
        failures++; $display("FAIL rand_hmastlock cycle %0d: got %b expected %b", c, bus.HMASTLOCK, m_lock);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_tenure();
    test_lock();
    test_split();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Central AHB bus arbiter that shares one AHB-Lite-style address/data bus among up to NUM_MST master ports.
- Each master port is an AHB_MST-type requester.
- Takes per-master HBUSREQ/HLOCK, drives one-hot HGRANT, and registers HMASTER/HMASTLOCK for the address/data mux.
- Selection is round-robin, with a tenure limit, locked-sequence hold and SPLIT masking.

Parameters:
- NUM_MST, 4, number of masters (2..16).
- DEF_MST, 0, default master index; granted when no eligible requester; never split-masked.
- MAX_BEATS, 16, maximum beats per tenure before forced re-arbitration; 0 = unlimited.

Ports:
- HCLK  input  1  bus clock, all state on rising edge.
- HRST_N  input  1  asynchronous active-low reset.
- HBUSREQ  input  NUM_MST  per-master bus request.
- HLOCK  input  NUM_MST  per-master locked-transfer request.
- HTRANS  input  2  muxed bus HTRANS of the current address-phase owner.
- HREADY  input  1  bus ready.
- HRESP  input  2  slave response.
- HSPLIT  input  NUM_MST  OR of slave split-resume vectors.
- HGRANT  output  NUM_MST  one-hot grant.
- HMASTER  output  4  address-phase owner index.
- HMASTLOCK  output  1  current transfer is locked.

Behaviour:
- Reset (async, HRST_N=0):
  - HGRANT = one-hot DEF_MST, HMASTER = DEF_MST, HMASTLOCK = 0.
  - split_mask = 0, rr_ptr = DEF_MST, beat_cnt = 0, rearb_pend = 0.
- Grant register: gnt_idx is updated only on edges with HREADY=1. HGRANT is decoded one-hot from gnt_idx and is always exactly one-hot.
- Owner pipeline:
  - On HREADY=1 edges: HMASTER <= gnt_idx and HMASTLOCK <= HLOCK[gnt_idx] & HBUSREQ[gnt_idx].
  - HMASTER therefore lags HGRANT by one HREADY cycle, per AHB.
  - HREADY=0 freezes HGRANT, HMASTER and HMASTLOCK.
- Eligible vector: elig = HBUSREQ & ~split_mask.
- Locked hold: if HLOCK[gnt_idx] & HBUSREQ[gnt_idx], no arbitration occurs. Grant stays, and tenure limit and rearb_pend are ignored.
- Arbitration point is an HREADY=1 edge, not locked hold, and any of:
  - ~HBUSREQ[gnt_idx];
  - HTRANS==IDLE;
  - rearb_pend;
  - MAX_BEATS!=0 & beat_cnt>=MAX_BEATS & (elig with bit gnt_idx cleared)!=0.
- Selection:
  - Pick the first set bit of elig, scanning circularly from rr_ptr+1 (mod NUM_MST) through rr_ptr.
  - If elig==0, pick DEF_MST.
  - rr_ptr <= selected index.
  - Current owner is selected again only when no other master is eligible.
- Tenure counter beat_cnt:
  - Cleared when gnt_idx changes.
  - Increments on HREADY=1 edges when HTRANS is NONSEQ or SEQ.
  - Saturates at MAX_BEATS.
- SPLIT/RETRY, two-cycle response:
  - First cycle (HREADY=0, HRESP=SPLIT) with HMASTER!=DEF_MST sets split_mask[HMASTER].
  - First cycle with HRESP=SPLIT or RETRY sets rearb_pend.
  - rearb_pend clears at the next arbitration point.
  - RETRY never sets split_mask.
  - SPLIT from DEF_MST is treated as RETRY.
- Split release: HSPLIT[i]=1 clears split_mask[i] on the next edge. If set and clear hit the same bit in the same cycle, set wins.
- Width rules:
  - Indices are 4-bit; bits above NUM_MST-1 of HGRANT do not exist.
  - rr_ptr wrap is NUM_MST-1 -> 0.
  - HBUSREQ/HLOCK/HSPLIT bits are sampled directly (assumed synchronous to HCLK).
- Reset mid-transfer: all state returns to reset values immediately. No pending split or retry survives reset.

Test Plan:
- Reset then idle:
  - Stimulus: HRST_N low, then high; HBUSREQ=0 for 5 cycles.
  - Required: HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0 throughout.
- Round-robin:
  - Stimulus: HBUSREQ=4'b1110, HTRANS=NONSEQ then IDLE every other cycle, HREADY=1.
  - Required: grant sequence 1,2,3,1,2,3; HMASTER follows each grant one cycle later.
- Tenure limit:
  - Stimulus: MAX_BEATS=4; m1 and m2 request; m1 drives SEQ continuously.
  - Required: grant moves to m2 after 4 beats.
  - Variant: with only m1 requesting, grant stays on m1 indefinitely.
- Lock:
  - Stimulus: m2 asserts HLOCK and HBUSREQ; m1 and m3 request; 20 beats.
  - Required: HGRANT stays 4'b0100 and HMASTLOCK=1.
  - On m2 dropping HLOCK and HBUSREQ, grant goes to m3.
- Split:
  - Stimulus: HMASTER=3; HRESP=SPLIT with HREADY=0, then HREADY=1.
  - Required: grant leaves m3; m3 is ignored while requesting.
  - Then HSPLIT[3]=1: m3 is granted at a later arbitration point.
  - Same-cycle set and clear of bit 3: mask remains set.
- Wait states:
  - Stimulus: HREADY=0 for 3 cycles while HBUSREQ changes.
  - Required: HGRANT, HMASTER and HMASTLOCK unchanged; arbitration resumes on the first HREADY=1 edge.
